// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between MEM/WB writebacks and queued MDU results
// Ports: clk_i/rst_i (async, active-high reset); pipe_we_i/pipe_addr_i/pipe_data_i MEM/WB write request;
// mdu_valid_i/mdu_addr_i/mdu_data_i/mdu_ready_o MDU result handshake; stall_o pipeline freeze while draining;
// rf_we_o/rf_addr_o/rf_data_o combinational register-file write port.
// Define WB_ARB_STATS_EN to add stall_cnt_o, a saturating count of stalled cycles.
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pipe_we_i,
  input  logic [4:0]  pipe_addr_i,
  input  logic [31:0] pipe_data_i,
  input  logic        mdu_valid_i,
  input  logic [4:0]  mdu_addr_i,
  input  logic [31:0] mdu_data_i,
  output logic        mdu_ready_o,
  output logic        stall_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_addr_o,
  output logic [31:0] rf_data_o
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0] stall_cnt_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, PEND, DRAIN} state_t;
  state_t state, state_nx;
  logic [36:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic pipe_req, pipe_win, pop, push, full, empty, drain;
  assign drain       = state == DRAIN;
  assign full        = count == CW'(DEPTH);
  assign empty       = count == '0;
  assign pipe_req    = pipe_we_i && pipe_addr_i != '0;
  assign pipe_win    = !rst_i && !drain && pipe_req;
  assign pop         = !rst_i && !empty && (drain || !pipe_req);
  assign mdu_ready_o = !rst_i && !full;
  // r0 results complete the handshake but are dropped here
  assign push        = mdu_valid_i && mdu_ready_o && mdu_addr_i != '0;
  assign stall_o     = drain;
  assign rf_we_o     = pipe_win || pop;
  assign rf_addr_o   = pop ? mem[rd_ptr][36:32] : pipe_win ? pipe_addr_i : '0;
  assign rf_data_o   = pop ? mem[rd_ptr][31:0] : pipe_win ? pipe_data_i : '0;
  assign count_nx    = count + CW'(push) - CW'(pop);
  // starvation counter saturates so it can never wrap back below the threshold
  assign wait_nx     = pop ? '0
                     : (pipe_win && !empty && wait_cnt != WW'(STARVE_MAX)) ? wait_cnt + WW'(1)
                     : wait_cnt;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = push ? PEND : IDLE;
      PEND:    state_nx = count_nx == '0 ? IDLE
                        : (wait_nx == WW'(STARVE_MAX) || (full && mdu_valid_i && pipe_win)) ? DRAIN
                        : PEND;
      DRAIN:   state_nx = count_nx == '0 ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      rd_ptr   <= rd_ptr + AW'(pop);
      wr_ptr   <= wr_ptr + AW'(push);
      count    <= count_nx;
      wait_cnt <= wait_nx;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {mdu_addr_i, mdu_data_i};
  end
`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt_o <= '0;
    else if (drain && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: scoreboard bench for wb_port_arbiter against a queue-based reference model
module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;
  logic clk = 0, rst = 1;
  logic pipe_we = 0, mdu_valid = 0;
  logic [4:0] pipe_addr = 0, mdu_addr = 0;
  logic [31:0] pipe_data = 0, mdu_data = 0;
  logic mdu_ready, stall, rf_we;
  logic [4:0] rf_addr;
  logic [31:0] rf_data;
`ifdef WB_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif
  always #5 clk = ~clk;
  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .pipe_we_i(pipe_we), .pipe_addr_i(pipe_addr), .pipe_data_i(pipe_data),
    .mdu_valid_i(mdu_valid), .mdu_addr_i(mdu_addr), .mdu_data_i(mdu_data),
    .mdu_ready_o(mdu_ready), .stall_o(stall),
    .rf_we_o(rf_we), .rf_addr_o(rf_addr), .rf_data_o(rf_data)
`ifdef WB_ARB_STATS_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );
  typedef struct packed {logic we; logic stall; logic ready; logic [15:0] sc;} ctl_t;
  ctl_t ctl_q[$];
  logic [36:0] sb_q[$];
  logic [36:0] m_q[$];
  int m_wait = 0, m_sc = 0;
  bit m_drain = 0;
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  // one clock of stimulus; the model decides this cycle's grant from the queue, then advances
  task automatic step(input logic we, input logic [4:0] pa, input logic [31:0] pd,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md);
    ctl_t c;
    bit popd, win, full0;
    @(posedge clk);
    #1;
    pipe_we = we; pipe_addr = pa; pipe_data = pd;
    mdu_valid = mv; mdu_addr = ma; mdu_data = md;
    full0 = m_q.size() == DEPTH;
    popd = 0;
    win = 0;
    c.ready = !full0;
    c.stall = m_drain;
    c.sc = 16'(m_sc);
    if (m_drain || (!(we && pa != 0) && m_q.size() > 0)) begin
      sb_q.push_back(m_q.pop_front());
      popd = 1;
    end else if (we && pa != 0) begin
      sb_q.push_back({pa, pd});
      win = 1;
    end
    c.we = popd || win;
    ctl_q.push_back(c);
    if (m_drain && m_sc < 65535) m_sc++;
    if (popd) m_wait = 0;
    else if (win && m_q.size() > 0 && m_wait < SMAX) m_wait++;
    if (!m_drain && (m_wait == SMAX || (full0 && mv && win))) m_drain = 1;
    if (mv && !full0 && ma != 0) m_q.push_back({ma, md});
    if (m_q.size() == 0) begin
      m_drain = 0;
      m_wait = 0;
    end
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask
  task automatic rstep(input int p_pipe, input int p_mdu);
    step($urandom_range(0, 99) < p_pipe, 5'($urandom), $urandom,
         $urandom_range(0, 99) < p_mdu, 5'($urandom), $urandom);
  endtask
  initial begin
    ctl_t c;
    logic [36:0] w;
    forever begin
      @(negedge clk);
      if (rst || ctl_q.size() == 0) continue;
      c = ctl_q.pop_front();
      chk("stall", 37'(stall), 37'(c.stall));
      chk("ready", 37'(mdu_ready), 37'(c.ready));
      chk("rf_we", 37'(rf_we), 37'(c.we));
`ifdef WB_ARB_STATS_EN
      chk("stall_cnt", 37'(stall_cnt), 37'(c.sc));
`endif
      if (rf_we) begin
        if (sb_q.size() == 0) chk("unexpected_write", {rf_addr, rf_data}, 37'h0);
        else begin
          w = sb_q.pop_front();
          chk("rf_write", {rf_addr, rf_data}, w);
        end
      end
    end
  end
  task automatic reset_now();
    @(negedge clk);
    #1;
    rst = 1;
    #1;
    chk("rst_stall", 37'(stall), 37'(0));
    chk("rst_we", 37'(rf_we), 37'(0));
    chk("rst_ready", 37'(mdu_ready), 37'(0));
`ifdef WB_ARB_STATS_EN
    chk("rst_stall_cnt", 37'(stall_cnt), 37'(0));
`endif
    pipe_we = 0; mdu_valid = 0;
    ctl_q.delete(); sb_q.delete(); m_q.delete();
    m_wait = 0; m_drain = 0; m_sc = 0;
    repeat (2) @(negedge clk);
    #1;
    rst = 0;
    #1;
    chk("post_rst_ready", 37'(mdu_ready), 37'(1));
    chk("post_rst_stall", 37'(stall), 37'(0));
  endtask
  initial begin
    #2;
    chk("init_stall", 37'(stall), 37'(0));
    chk("init_we", 37'(rf_we), 37'(0));
    chk("init_ready", 37'(mdu_ready), 37'(0));
    @(negedge clk);
    #1;
    rst = 0;
    // pipeline-only write
    step(1, 5, 32'hA5A5_0001, 0, 0, 0);
    // single MDU result written the cycle after its push
    step(0, 0, 0, 1, 7, 32'h1234);
    idle(); idle();
    // starvation forces a drain
    step(0, 0, 0, 1, 9, 32'hCAFE_0009);
    for (int i = 0; i < 7; i++) step(1, 5'(i + 1), 32'h1000 + i, 0, 0, 0);
    idle();
    // fill the FIFO while the pipeline writes, then a blocked third result
    step(1, 3, 32'h3333, 1, 10, 32'hAAAA);
    step(1, 4, 32'h4444, 1, 11, 32'hBBBB);
    step(1, 6, 32'h6666, 1, 12, 32'hCCCC);
    for (int i = 0; i < 3; i++) step(1, 13, 32'hD000 + i, 0, 0, 0);
    idle();
    // r0 requests from both sources
    step(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
    idle();
    for (int i = 0; i < 300; i++) rstep(30, 40);
    for (int i = 0; i < 300; i++) rstep(70, 50);
    for (int i = 0; i < 300; i++) rstep(95, 60);
    for (int i = 0; i < 5; i++) idle();
    // reset while draining
    step(1, 3, 32'h1, 1, 20, 32'h20);
    step(1, 3, 32'h2, 1, 21, 32'h21);
    step(1, 3, 32'h3, 1, 22, 32'h22);
    step(0, 0, 0, 0, 0, 0);
    reset_now();
    for (int i = 0; i < 200; i++) rstep(60, 50);
    for (int i = 0; i < 4; i++) idle();
    repeat (2) @(negedge clk);
    #1;
    chk("sb_drained", 37'(sb_q.size()), 37'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
